tmemory: RTL and testbench
==========================

TMEMORY -- requirements
Module: tmemory

Interface
REQ-001 Parameter ADDR_W, default 20, word-address width (1M words).
REQ-002 Parameter DATA_W, default 64, data word width.
REQ-003 Parameter TAG_W, default 8, tag width per word.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 o_ad  input  DATA_W  multiplexed bus from CPU; carries the address during strobe, write data otherwise.
REQ-008 o_tag  input  TAG_W  write tag from CPU.
REQ-009 o_astb  input  1  address strobe.
REQ-010 o_atomic  input  1  read-modify-write flag.
REQ-011 o_rd  input  1  read request.
REQ-012 o_wr  input  1  write request.
REQ-013 i_data  output  DATA_W  read data to CPU.
REQ-014 i_tag  output  TAG_W  read tag to CPU.
REQ-015 waddr  internal  ADDR_W  latched word address; hierarchically visible to trace monitors by this name.

Function
REQ-016 Storage: 2^ADDR_W words of DATA_W data plus TAG_W tag; all words are zero at simulation start.
REQ-017 Address latch: at a rising edge with o_astb=1, waddr <= o_ad[ADDR_W-1:0]; o_ad upper bits are ignored.
REQ-018 waddr holds its value until the next strobe; it never auto-increments.
REQ-019 Effective address ea = o_astb ? o_ad[ADDR_W-1:0] : waddr.
REQ-020 Read: at a rising edge with o_rd=1, {i_data,i_tag} <= mem[ea]; the data is valid from that edge until the next read, so latency is one cycle.
REQ-021 Outputs i_data/i_tag hold their last value when o_rd=0.
REQ-022 Write: at a rising edge with o_wr=1 and o_astb=0, mem[waddr] <= o_ad, and the tag <= o_tag.
REQ-023 o_wr together with o_astb is ignored, because the bus carries an address; no write occurs.
REQ-024 o_rd and o_wr in the same cycle: the read returns the old contents (read-before-write), and then the write takes effect.
REQ-025 Atomic: when o_atomic=1, a read followed by a write without a new strobe targets the same waddr; no locking is required (single master), and o_atomic has no other effect.
REQ-026 No address range check; all 2^ADDR_W addresses are present, and no error or timeout is ever signalled.
REQ-027 Back-to-back operations are permitted every cycle, with no wait states.

Reset
REQ-028 While reset=1: waddr=0, i_data=0, i_tag=0, and reads and writes are blocked.
REQ-029 Reset does not alter memory contents.
REQ-030 Deasserting reset mid-sequence: the first edge after release obeys REQ-017..REQ-024 normally.

Verification
REQ-031 Strobe 0x40000, next cycle o_wr with data 0x0123456789ABCDEF and tag 0x35; strobe 0x40000 with o_rd -> next cycle i_data=0x0123456789ABCDEF, i_tag=0x35.
REQ-032 Strobe with o_ad=0xFFFF_FFFF_FFF0_0005 -> waddr=0x00005; a read returns the word at 0x00005.
REQ-033 Atomic RMW at 0x00010 (holds 5): strobe+rd returns 5; o_wr with 6 and no strobe -> re-read of 0x00010 gives 6, and 0x00011 is unchanged (0).
REQ-034 Same-cycle rd+wr at a word holding 0xAA, writing 0xBB -> i_data=0xAA; a subsequent read gives 0xBB.
REQ-035 Assert reset asynchronously mid-run -> i_data/i_tag/waddr go to 0 immediately; previously written words are still readable after release.
REQ-036 o_wr asserted with o_astb -> memory is unchanged and waddr is updated.

Source files
------------

// File: rtl/tmemory.sv
// Purpose : tagged word memory behind a multiplexed address/data CPU bus.
// Latency : reads return one cycle after o_rd; writes land at the issuing edge.
// Backpres: none; a new operation is accepted on every clock edge.
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   o_ad         CPU bus: word address while o_astb=1, write data otherwise
//   o_tag        write tag from CPU
//   o_astb       address strobe; latches o_ad[ADDR_W-1:0] into waddr
//   o_atomic     read-modify-write marker (informational only)
//   o_rd, o_wr   read / write requests
//   i_data,i_tag registered read data and tag back to the CPU
module tmemory #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] o_ad,
  input  logic [TAG_W-1:0]  o_tag,
  input  logic              o_astb,
  input  logic              o_atomic,
  input  logic              o_rd,
  input  logic              o_wr,
  output logic [DATA_W-1:0] i_data,
  output logic [TAG_W-1:0]  i_tag
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } word_t;

  // Storage is never reset: contents must survive a reset pulse.
  word_t mem [DEPTH];

  // Latched word address; trace monitors look it up by this name.
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] ea;
  logic              wr_en;

  // A single master owns the bus, so a read-modify-write needs no lock:
  // holding waddr between the read and the write is enough.
  logic unused_atomic;
  assign unused_atomic = o_atomic;

  // A strobe cycle addresses the bus value directly so strobe+read works
  // in one cycle; otherwise the previously latched address is used.
  assign ea = o_astb ? o_ad[ADDR_W-1:0] : waddr;

  // While the strobe is high the bus carries an address, not data, so a
  // concurrent write request is dropped rather than storing the address.
  assign wr_en = o_wr & ~o_astb & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr <= '0;
    end else if (o_astb) begin
      waddr <= o_ad[ADDR_W-1:0];
    end
  end

  // Read port: the non-blocking read samples the old word, which gives
  // read-before-write ordering when o_rd and o_wr share a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_data <= '0;
      i_tag  <= '0;
    end else if (o_rd) begin
      i_data <= mem[ea].data;
      i_tag  <= mem[ea].tag;
    end
  end

  // Write port: reset is sampled synchronously here so the array stays a
  // plain RAM and is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= '{data: o_ad, tag: o_tag};
    end
  end

endmodule

// File: tb/tb_tmemory.sv
module tb_tmemory;

  logic        clk;
  logic        reset;
  logic [63:0] o_ad;
  logic [7:0]  o_tag;
  logic        o_astb;
  logic        o_atomic;
  logic        o_rd;
  logic        o_wr;
  logic [63:0] i_data;
  logic [7:0]  i_tag;

  int total;
  int bad;

  tmemory dut (
    .clk      (clk),
    .reset    (reset),
    .o_ad     (o_ad),
    .o_tag    (o_tag),
    .o_astb   (o_astb),
    .o_atomic (o_atomic),
    .o_rd     (o_rd),
    .o_wr     (o_wr),
    .i_data   (i_data),
    .i_tag    (i_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle, let it be taken at the next rising edge, and
  // return 1 time unit after that edge so outputs can be sampled.
  task automatic cyc(input logic astb, input logic atomic, input logic rd,
                     input logic wr, input logic [63:0] ad, input logic [7:0] tag);
    o_astb   = astb;
    o_atomic = atomic;
    o_rd     = rd;
    o_wr     = wr;
    o_ad     = ad;
    o_tag    = tag;
    @(posedge clk);
    #1;
    o_astb = 1'b0; o_atomic = 1'b0; o_rd = 1'b0; o_wr = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", i_data); end
    total++;
    if (i_tag !== 8'h0) begin bad++; $display("FAIL reset_tag got=%h exp=0", i_tag); end
    total++;
    if (dut.waddr !== 20'h0) begin bad++; $display("FAIL reset_waddr got=%h exp=0", dut.waddr); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    cyc(1, 0, 0, 0, 64'h40000, 8'h00);
    total++;
    if (dut.waddr !== 20'h40000) begin bad++; $display("FAIL basic_waddr got=%h exp=40000", dut.waddr); end
    cyc(0, 0, 0, 1, 64'h0123456789ABCDEF, 8'h35);
    cyc(1, 0, 1, 0, 64'h40000, 8'h00);
    total++;
    if (i_data !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL basic_data got=%h exp=0123456789abcdef", i_data); end
    total++;
    if (i_tag !== 8'h35) begin bad++; $display("FAIL basic_tag got=%h exp=35", i_tag); end
  endtask

  task automatic test_addr_mask;
    cyc(1, 0, 0, 0, 64'h5, 8'h00);
    cyc(0, 0, 0, 1, 64'h1111, 8'h11);
    cyc(1, 0, 0, 0, 64'h0000_0000_0000_0007, 8'h00);
    cyc(1, 0, 0, 0, 64'hFFFF_FFFF_FFF0_0005, 8'h00);
    total++;
    if (dut.waddr !== 20'h00005) begin bad++; $display("FAIL mask_waddr got=%h exp=00005", dut.waddr); end
    cyc(0, 0, 1, 0, 64'h0, 8'h00);
    total++;
    if (i_data !== 64'h1111) begin bad++; $display("FAIL mask_data got=%h exp=1111", i_data); end
    total++;
    if (i_tag !== 8'h11) begin bad++; $display("FAIL mask_tag got=%h exp=11", i_tag); end
    // Outputs hold with o_rd low
    cyc(1, 0, 0, 0, 64'h40000, 8'h00);
    cyc(0, 0, 0, 0, 64'h0, 8'h00);
    total++;
    if (i_data !== 64'h1111) begin bad++; $display("FAIL hold_data got=%h exp=1111", i_data); end
  endtask

  task automatic test_atomic;
    cyc(1, 0, 0, 0, 64'h10, 8'h00);
    cyc(0, 0, 0, 1, 64'h5, 8'h00);
    cyc(1, 1, 1, 0, 64'h10, 8'h00);
    total++;
    if (i_data !== 64'h5) begin bad++; $display("FAIL atomic_read got=%h exp=5", i_data); end
    cyc(0, 1, 0, 1, 64'h6, 8'h00);
    cyc(0, 1, 1, 0, 64'h0, 8'h00);
    total++;
    if (i_data !== 64'h6) begin bad++; $display("FAIL atomic_reread got=%h exp=6", i_data); end
    cyc(1, 0, 1, 0, 64'h11, 8'h00);
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL atomic_neighbour got=%h exp=0", i_data); end
  endtask

  task automatic test_rdwr;
    cyc(1, 0, 0, 0, 64'h20, 8'h00);
    cyc(0, 0, 0, 1, 64'hAA, 8'h01);
    cyc(0, 0, 1, 1, 64'hBB, 8'h02);
    total++;
    if (i_data !== 64'hAA) begin bad++; $display("FAIL rdwr_old_data got=%h exp=aa", i_data); end
    total++;
    if (i_tag !== 8'h01) begin bad++; $display("FAIL rdwr_old_tag got=%h exp=01", i_tag); end
    cyc(0, 0, 1, 0, 64'h0, 8'h00);
    total++;
    if (i_data !== 64'hBB) begin bad++; $display("FAIL rdwr_new_data got=%h exp=bb", i_data); end
    total++;
    if (i_tag !== 8'h02) begin bad++; $display("FAIL rdwr_new_tag got=%h exp=02", i_tag); end
  endtask

  task automatic test_wr_astb;
    cyc(1, 0, 0, 0, 64'h30, 8'h00);
    cyc(0, 0, 0, 1, 64'h77, 8'h07);
    cyc(1, 0, 0, 1, 64'h30, 8'h09);
    cyc(1, 0, 0, 1, 64'h31, 8'h09);
    total++;
    if (dut.waddr !== 20'h00031) begin bad++; $display("FAIL wrastb_waddr got=%h exp=00031", dut.waddr); end
    cyc(1, 0, 1, 0, 64'h30, 8'h00);
    total++;
    if (i_data !== 64'h77) begin bad++; $display("FAIL wrastb_mem30 got=%h exp=77", i_data); end
    total++;
    if (i_tag !== 8'h07) begin bad++; $display("FAIL wrastb_tag30 got=%h exp=07", i_tag); end
    cyc(1, 0, 1, 0, 64'h31, 8'h00);
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL wrastb_mem31 got=%h exp=0", i_data); end
  endtask

  task automatic test_back_to_back;
    cyc(1, 0, 0, 0, 64'h50, 8'h00);
    cyc(0, 0, 0, 1, 64'h1, 8'h0A);
    cyc(0, 0, 0, 1, 64'h2, 8'h0B);
    total++;
    if (dut.waddr !== 20'h00050) begin bad++; $display("FAIL b2b_waddr got=%h exp=00050", dut.waddr); end
    cyc(1, 0, 1, 0, 64'h50, 8'h00);
    total++;
    if (i_data !== 64'h2) begin bad++; $display("FAIL b2b_data50 got=%h exp=2", i_data); end
    total++;
    if (i_tag !== 8'h0B) begin bad++; $display("FAIL b2b_tag50 got=%h exp=0b", i_tag); end
    cyc(1, 0, 1, 0, 64'h51, 8'h00);
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL b2b_data51 got=%h exp=0", i_data); end
  endtask

  task automatic test_async_reset;
    cyc(1, 0, 1, 0, 64'h40000, 8'h00);
    total++;
    if (i_data !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL prerst_data got=%h exp=0123456789abcdef", i_data); end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", i_data); end
    total++;
    if (i_tag !== 8'h0) begin bad++; $display("FAIL arst_tag got=%h exp=0", i_tag); end
    total++;
    if (dut.waddr !== 20'h0) begin bad++; $display("FAIL arst_waddr got=%h exp=0", dut.waddr); end
    // Requests during reset are blocked
    cyc(0, 0, 0, 1, 64'hDEAD, 8'h5A);
    cyc(1, 0, 1, 0, 64'h40000, 8'h00);
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL inrst_read got=%h exp=0", i_data); end
    reset = 1'b0;
    cyc(1, 0, 1, 0, 64'h40000, 8'h00);
    total++;
    if (i_data !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL postrst_data got=%h exp=0123456789abcdef", i_data); end
    total++;
    if (i_tag !== 8'h35) begin bad++; $display("FAIL postrst_tag got=%h exp=35", i_tag); end
    cyc(1, 0, 1, 0, 64'h0, 8'h00);
    total++;
    if (i_data !== 64'h0) begin bad++; $display("FAIL postrst_addr0 got=%h exp=0", i_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    o_ad     = '0;
    o_tag    = '0;
    o_astb   = 1'b0;
    o_atomic = 1'b0;
    o_rd     = 1'b0;
    o_wr     = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_addr_mask();
    test_atomic();
    test_rdwr();
    test_wr_astb();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
